// File: rtl/fifo1_arb_pkg.sv
// Shared types and helpers for the Fifo1 enqueue arbiters.
package fifo1_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int STALL_CNT_W = 16;

  // Width of a grant index for n requesters (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo1_enq_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int s;
    logic [IDX_W-1:0] c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = 0;
    c     = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      c = IDX_W'(s);
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/fifo1_enq_arbiter.sv
// Round-robin arbiter with lockable bursts sharing one Fifo1 enqueue port.
module fifo1_enq_arbiter
  import fifo1_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DATA_WIDTH   = 384,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NREQ-1:0]            req_enq__ENA,
  input  logic [NREQ*DATA_WIDTH-1:0] req_enq_v,
  input  logic [NREQ-1:0]            req_lock,
  output logic [NREQ-1:0]            req_enq__RDY,
  output logic                       fifo_enq__ENA,
  output logic [DATA_WIDTH-1:0]      fifo_enq_v,
  input  logic                       fifo_enq__RDY,
  output logic [2:0]                 last_grant,
  output logic                       last_grant_valid,
  output logic [STALL_CNT_W-1:0]     stall_cnt
);

  localparam int IDX_W = clog2(NREQ);
  localparam int TO_W  = 8;

  arb_state_t             state_reg, state_next;
  logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]       lock_owner_reg, lock_owner_next;
  logic [TO_W-1:0]        idle_cnt_reg, idle_cnt_next;
  logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
  logic                   last_grant_valid_reg, last_grant_valid_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  logic [NREQ-1:0]        eligible, pick_grant;
  logic [IDX_W-1:0]       pick_ptr, pick_idx;
  logic                   pick_any, fire;
  logic [DATA_WIDTH-1:0]  req_word [NREQ];

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
      assign req_word[gi] = req_enq_v[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // While locked only the owner is visible to the picker.
  always_comb begin
    if (state_reg == ARB_LOCKED) begin
      eligible = req_enq__ENA & (NREQ'(1) << lock_owner_reg);
      pick_ptr = lock_owner_reg;
    end else begin
      eligible = req_enq__ENA;
      pick_ptr = rr_ptr_reg;
    end
  end

  rr_pick #(.N(NREQ), .IDX_W(IDX_W)) u_pick (
    .req   (eligible),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg            <= ARB_IDLE;
      rr_ptr_reg           <= '0;
      lock_owner_reg       <= '0;
      idle_cnt_reg         <= '0;
      last_grant_reg       <= '0;
      last_grant_valid_reg <= 1'b0;
    end else begin
      state_reg            <= state_next;
      rr_ptr_reg           <= rr_ptr_next;
      lock_owner_reg       <= lock_owner_next;
      idle_cnt_reg         <= idle_cnt_next;
      last_grant_reg       <= last_grant_next;
      last_grant_valid_reg <= last_grant_valid_next;
    end
  end

  // A fire always wins over a coincident lock timeout.
  always_comb begin
    state_next            = state_reg;
    rr_ptr_next           = rr_ptr_reg;
    lock_owner_next       = lock_owner_reg;
    idle_cnt_next         = idle_cnt_reg;
    last_grant_next       = last_grant_reg;
    last_grant_valid_next = last_grant_valid_reg;
    if (fire) begin
      last_grant_next       = pick_idx;
      last_grant_valid_next = 1'b1;
      idle_cnt_next         = '0;
      if (req_lock[pick_idx]) begin
        state_next      = ARB_LOCKED;
        lock_owner_next = pick_idx;
      end else begin
        state_next  = ARB_IDLE;
        rr_ptr_next = inc_wrap(pick_idx);
      end
    end else if (state_reg == ARB_LOCKED && !req_enq__ENA[lock_owner_reg]) begin
      if (idle_cnt_reg == TO_W'(LOCK_TIMEOUT - 1)) begin
        state_next    = ARB_IDLE;
        rr_ptr_next   = inc_wrap(lock_owner_reg);
        idle_cnt_next = '0;
      end else begin
        idle_cnt_next = idle_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    fire          = fifo_enq__RDY && !RST && pick_any;
    req_enq__RDY  = fire ? pick_grant : '0;
    fifo_enq__ENA = fire;
    fifo_enq_v    = fire ? req_word[pick_idx] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_reg <= '0;
    end else if ((|req_enq__ENA) && !fifo_enq__RDY && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign last_grant       = 3'(last_grant_reg);
  assign last_grant_valid = last_grant_valid_reg;
  assign stall_cnt        = stall_cnt_reg;

endmodule

// File: doc/fifo1_enq_arbiter.md
# fifo1_enq_arbiter

Round-robin arbiter that shares the enqueue port of a single-element 384-bit Fifo1 between NREQ requesters. It sits between the producer modules and the Fifo1 `in_enq` method. It grants at most one enqueue per cycle and forwards the winner's payload. Requesters may lock the port for back-to-back bursts, and the block keeps a stall counter for performance monitoring.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DATA_WIDTH, 384, payload width
- LOCK_TIMEOUT, 16, idle cycles before a held lock is released (1..255)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- req_enq__ENA  in  NREQ  per-requester enqueue request; must not depend combinationally on req_enq__RDY
- req_enq_v  in  NREQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_lock  in  NREQ  sampled with a fire; 1 means keep the grant after this enqueue
- req_enq__RDY  out  NREQ  grant; one-hot or zero
- fifo_enq__ENA  out  1  to Fifo1 in_enq__ENA
- fifo_enq_v  out  DATA_WIDTH  to Fifo1 in_enq_v
- fifo_enq__RDY  in  1  from Fifo1 in_enq__RDY
- last_grant  out  3  index of the most recent fired requester
- last_grant_valid  out  1  set after the first fire since reset
- stall_cnt  out  16  saturating count of cycles with a pending request and fifo_enq__RDY=0

## Operation
- Fire for requester i: req_enq__ENA[i] && req_enq__RDY[i]. At most one fire per cycle.
- State IDLE, winner selection: the first requester with ENA=1, searching from rr_ptr upward and wrapping modulo NREQ.
- State LOCKED, winner selection: only lock_owner is eligible. Other requesters see RDY=0 even when the Fifo is free.
- req_enq__RDY[w] = fifo_enq__RDY && (w is the winner). If no requester is eligible, all RDY bits are 0.
- fifo_enq__ENA = OR of all fires. fifo_enq_v = payload of the winner. When there is no fire, fifo_enq_v = 0.
- On a fire by requester i:
  - last_grant <= i, last_grant_valid <= 1.
  - If req_lock[i]=1: next state LOCKED, lock_owner <= i, idle_cnt <= 0.
  - Else: next state IDLE, rr_ptr <= (i+1) mod NREQ.
- In LOCKED, owner ENA=0: idle_cnt increments. When idle_cnt reaches LOCK_TIMEOUT-1, the lock releases to IDLE and rr_ptr <= owner+1. An owner fire resets idle_cnt.
- In LOCKED, owner ENA=1 but fifo_enq__RDY=0: the lock holds and idle_cnt does not increment.
- stall_cnt increments when any req_enq__ENA=1 and fifo_enq__RDY=0. It saturates at 0xFFFF.
- Reset values: state IDLE, rr_ptr=0, lock_owner=0, idle_cnt=0, last_grant=0, last_grant_valid=0, stall_cnt=0. All outputs are 0 while no request is asserted.
- RST mid-lock: the block returns to IDLE immediately. No fire is generated in the reset cycle; all RDY bits are forced to 0 while RST=1.

## Timing
- Grant path is combinational, zero latency: ENA to RDY to fifo_enq__ENA in the same cycle.
- Fifo1 accepts one element and then drops RDY until dequeued. Back-to-back enqueue is only possible when Fifo1 dequeues in the intervening cycle. The arbiter does not assume a throughput rate.
- rr_ptr, state, lock_owner, last_grant and counters update on the posedge following the fire. They first affect arbitration one cycle later.
- Same-cycle events: an owner fire with lock=0 while idle_cnt is at timeout resolves as a fire, and the next state is IDLE with rr_ptr = owner+1.
- Wrap-around: a fire by NREQ-1 sets rr_ptr to 0.

## Structure
- Shared package (fifo1_arb_pkg): state enum {ARB_IDLE, ARB_LOCKED}, constant STALL_CNT_W=16, and the grant-index width function clog2(NREQ).
- One sub-module: rr_pick, a combinational first-set-bit-from-pointer finder (req vector plus pointer in, one-hot grant and index out). It is reused by other arbiters in the design.
- The FSM, counters and payload mux live in the top module.

## Test plan
- Reset, then ENA=4'b0000 -> all RDY=0, fifo_enq__ENA=0, last_grant_valid=0, stall_cnt=0.
- ENA=4'b1111 constantly, Fifo dequeued every cycle -> fire order 0,1,2,3,0 and fifo_enq_v matches each winner's payload.
- Requester 2 fires with req_lock=1, then ENA=4'b1111 for 3 more fires with lock=1 then lock=0 -> all four fires go to 2, then rr_ptr=3 and the next winner is 3.
- Lock held by requester 1, owner ENA=0 for 16 cycles while requester 0 requests -> requester 0 first sees RDY on cycle 17, and the state is IDLE.
- fifo_enq__RDY=0 for 20 cycles with ENA=4'b0100 -> no fire, stall_cnt=20. Forcing stall_cnt to 0xFFFE and stalling 5 more cycles -> stall_cnt=0xFFFF.
- RST=1 in the middle of a LOCKED burst -> next cycle state IDLE, rr_ptr=0, and requester 0 wins when all requesters request.
